// File: rtl/mac_result_drain_if.sv
// Result-drain bus: per-MAC result capture inputs, flush, and the lane-serial output stream.
// master is the producer/consumer side, slave is the drain block.
interface mac_result_drain_if #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic signed [ACC_W-1:0] acc_in_0;
  logic signed [ACC_W-1:0] acc_in_1;
  logic signed [ACC_W-1:0] acc_in_2;
  logic signed [ACC_W-1:0] acc_in_3;
  logic [N_MACS-1:0]       valid_in;
  logic                    flush;
  logic signed [ACC_W-1:0] m_data;
  logic [1:0]              m_lane;
  logic                    m_last;
  logic                    m_valid;
  logic                    m_ready;
  logic                    stall;
  logic                    err_overrun;
  logic [CW-1:0]           frame_cnt;

  modport master (
    output acc_in_0, acc_in_1, acc_in_2, acc_in_3, valid_in, flush, m_ready,
    input  m_data, m_lane, m_last, m_valid, stall, err_overrun, frame_cnt
  );

  modport slave (
    input  acc_in_0, acc_in_1, acc_in_2, acc_in_3, valid_in, flush, m_ready,
    output m_data, m_lane, m_last, m_valid, stall, err_overrun, frame_cnt
  );
endinterface

// File: rtl/mac_result_drain.sv
// Gathers the four MAC results into frames, queues them in a small FIFO and
// streams them out one lane per beat; flags results that overwrite undrained ones.
module mac_result_drain #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  mac_result_drain_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic signed [ACC_W-1:0] acc [N_MACS];
  logic signed [ACC_W-1:0] cap [N_MACS];
  logic signed [ACC_W-1:0] mem [DEPTH][N_MACS];
  logic [N_MACS-1:0]       pend;
  logic [N_MACS-1:0]       ovr;
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rptr;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic                    full;
  logic                    empty;
  logic [1:0]              beat;
  logic                    err;
  logic                    all_pend;
  logic                    hs;
  logic                    pop;
  logic                    push;

  assign acc[0] = bus.acc_in_0;
  assign acc[1] = bus.acc_in_1;
  assign acc[2] = bus.acc_in_2;
  assign acc[3] = bus.acc_in_3;

  // A full FIFO can still accept a frame when the head frame's last beat leaves this cycle.
  always_comb begin
    all_pend = &pend;
    hs       = !empty && bus.m_ready;
    pop      = hs && (beat == 2'd3);
    push     = all_pend && (!full || pop);
    cnt_next = cnt;
    if (push && !pop)
      cnt_next = cnt + CW'(1);
    else if (pop && !push)
      cnt_next = cnt - CW'(1);
  end

  for (genvar g = 0; g < N_MACS; g++) begin : g_lane
    assign ovr[g] = bus.valid_in[g] && pend[g] && !push && !bus.flush;

    always_ff @(posedge clk) begin
      if (rst) begin
        pend[g] <= 1'b0;
        cap[g]  <= '0;
      end else if (bus.flush) begin
        pend[g] <= 1'b0;
      end else if (bus.valid_in[g]) begin
        pend[g] <= 1'b1;
        cap[g]  <= acc[g];
      end else if (push) begin
        pend[g] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (|ovr)
      err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push) begin
      mem[wptr][0] <= cap[0];
      mem[wptr][1] <= cap[1];
      mem[wptr][2] <= cap[2];
      mem[wptr][3] <= cap[3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      beat  <= 2'd0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (hs)
        beat <= beat + 2'd1;
      cnt   <= cnt_next;
      full  <= (cnt_next == CW'(DEPTH));
      empty <= (cnt_next == '0);
    end
  end

  // beat is always 0 while empty, so lane/last fall to 0 without extra gating.
  assign bus.m_valid     = !empty;
  assign bus.m_data      = empty ? '0 : mem[rptr][beat];
  assign bus.m_lane      = beat;
  assign bus.m_last      = (beat == 2'd3);
  assign bus.stall       = all_pend && !push;
  assign bus.err_overrun = err;
  assign bus.frame_cnt   = cnt;
endmodule

// File: tb/tb_mac_result_drain.sv
// Randomized and directed bench for mac_result_drain against a queue-based frame model.
module tb_mac_result_drain;
  localparam int ACC_W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_result_drain_if #(.ACC_W(ACC_W), .N_MACS(4), .DEPTH(DEPTH)) bus ();
  mac_result_drain #(.ACC_W(ACC_W), .N_MACS(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference: pending lanes, a queue of whole frames, position within the head frame.
  logic [3:0]  md_pend;
  logic [15:0] md_cap [4];
  logic [63:0] md_q [$];
  int          md_beat;
  logic        md_err;
  bit          just_rst;

  function automatic void model_reset();
    md_pend = '0;
    for (int i = 0; i < 4; i++) md_cap[i] = '0;
    md_q.delete();
    md_beat = 0;
    md_err  = 1'b0;
  endfunction

  function automatic bit model_push(input logic rdy);
    bit pop;
    pop = (md_q.size() > 0) && rdy && (md_beat == 3);
    return (md_pend == 4'hF) && ((md_q.size() < DEPTH) || pop);
  endfunction

  task automatic check_outputs(input logic rdy);
    bit v;
    logic [63:0] f;
    logic [15:0] d;
    v = md_q.size() > 0;
    chk("m_valid", 32'(bus.m_valid), 32'(v));
    if (v) begin
      f = md_q[0];
      d = f[md_beat*16 +: 16];
      chk("m_data", 32'(bus.m_data[ACC_W-1:0]), 32'(d));
      chk("m_lane", 32'(bus.m_lane), 32'(md_beat));
      chk("m_last", 32'(bus.m_last), 32'(md_beat == 3));
    end else if (just_rst) begin
      chk("rst_m_data", 32'(bus.m_data[ACC_W-1:0]), 32'(0));
      chk("rst_m_lane", 32'(bus.m_lane), 32'(0));
      chk("rst_m_last", 32'(bus.m_last), 32'(0));
    end
    chk("stall", 32'(bus.stall), 32'((md_pend == 4'hF) && !model_push(rdy)));
    chk("err_overrun", 32'(bus.err_overrun), 32'(md_err));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(md_q.size()));
  endtask

  task automatic model_update(input logic [3:0] v, input logic [15:0] a [4],
                              input logic fl, input logic rdy, input logic rs);
    bit hs, pop, push;
    if (rs) begin
      model_reset();
      return;
    end
    hs   = (md_q.size() > 0) && rdy;
    pop  = hs && (md_beat == 3);
    push = model_push(rdy);
    if (fl) begin
      md_pend = '0;
      md_q.delete();
      md_beat = 0;
      return;
    end
    if (hs) md_beat = (md_beat + 1) % 4;
    if (pop) void'(md_q.pop_front());
    if (push) md_q.push_back({md_cap[3], md_cap[2], md_cap[1], md_cap[0]});
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (md_pend[i] && !push) md_err = 1'b1;
        md_cap[i]  = a[i];
        md_pend[i] = 1'b1;
      end else if (push) begin
        md_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3,
                      input logic fl, input logic rdy, input logic rs);
    logic [15:0] a [4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    bus.valid_in = v;
    bus.acc_in_0 = a0;
    bus.acc_in_1 = a1;
    bus.acc_in_2 = a2;
    bus.acc_in_3 = a3;
    bus.flush    = fl;
    bus.m_ready  = rdy;
    rst          = rs;
    #1;
    check_outputs(rdy);
    model_update(v, a, fl, rdy, rs);
    just_rst = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(4'h0, 0, 0, 0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic frame(input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3, input logic rdy);
    step(4'hF, a0, a1, a2, a3, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_in = '0;
    bus.acc_in_0 = '0;
    bus.acc_in_1 = '0;
    bus.acc_in_2 = '0;
    bus.acc_in_3 = '0;
    bus.flush    = 1'b0;
    bus.m_ready  = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    just_rst = 1'b1;

    // single frame with boundary values
    frame(16'd100, 16'hFFFB, 16'h7FFF, 16'h8000, 1'b1);
    idle(8, 1'b1);

    // lanes completing on successive cycles
    step(4'b0001, 16'd1, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 0, 16'd2, 0, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 0, 0, 16'd3, 0, 1'b0, 1'b1, 1'b0);
    step(4'b1000, 0, 0, 0, 16'd4, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);

    // backpressure: five frames into a four-deep FIFO
    for (int k = 1; k <= 5; k++)
      frame(16'(10*k), 16'(10*k+1), 16'(10*k+2), 16'(10*k+3), 1'b0);
    idle(4, 1'b0);
    idle(26, 1'b1);

    // overrun on lane 2
    step(4'b0100, 0, 0, 16'd7, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 0, 0, 16'd9, 0, 1'b0, 1'b1, 1'b0);
    step(4'b1011, 16'd5, 16'd6, 0, 16'd8, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);

    // flush in the middle of the first buffered frame
    frame(16'd21, 16'd22, 16'd23, 16'd24, 1'b0);
    frame(16'd31, 16'd32, 16'd33, 16'd34, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);
    step(4'hF, 16'd99, 16'd99, 16'd99, 16'd99, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    frame(16'd41, 16'd42, 16'd43, 16'd44, 1'b1);
    idle(7, 1'b1);

    // reset with a full FIFO and the overrun flag set
    for (int k = 0; k < 5; k++) frame(16'(k), 16'(k), 16'(k), 16'(k), 1'b0);
    step(4'b0001, 16'd77, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(4'h0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    frame(16'd100, 16'hFFFB, 16'h7FFF, 16'h8000, 1'b1);
    idle(8, 1'b1);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 3) == 0);
      step(v, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 299) == 0));
    end
    idle(30, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
